tl_phase_sequencer: RTL



---
 rtl/tl_pkg.sv | 35 +++
 rtl/tl_phase_timer.sv | 42 ++++
 rtl/tl_phase_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase sequencer.
// Holds the state encoding and the lamp vector for each state.
// The lamp bits are ordered {HG, HY, HR, FG, FY, FR}.
package tl_pkg;

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    localparam logic [5:0] LAMP_HG  = 6'b100_001;
    localparam logic [5:0] LAMP_HY  = 6'b010_001;
    localparam logic [5:0] LAMP_AR1 = 6'b001_001;
    localparam logic [5:0] LAMP_FG  = 6'b001_100;
    localparam logic [5:0] LAMP_FY  = 6'b001_010;
    localparam logic [5:0] LAMP_AR2 = 6'b001_001;

    // Illegal codes show highway green: they fall back to S_HG on the next edge.
    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            S_HG:    lamps_of = LAMP_HG;
            S_HY:    lamps_of = LAMP_HY;
            S_AR1:   lamps_of = LAMP_AR1;
            S_FG:    lamps_of = LAMP_FG;
            S_FY:    lamps_of = LAMP_FY;
            S_AR2:   lamps_of = LAMP_AR2;
            default: lamps_of = LAMP_HG;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: counts enabled cycles spent in the current state.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the count
//   en    - count enable; nothing changes while low
//   clr   - clear the count (takes effect only with en)
//   cnt   - current count, saturating at 2^CNT_W-1
module tl_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tl_phase_sequencer.sv
// Highway / farm-road lamp sequencer with car sensor, latched pedestrian
// request and emergency preemption.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   enable            - when low, state, timer and ped latch freeze
//   car, ped_req, emg - farm car sensor, ped button, emergency preempt
//   HG HY HR FG FY FR - lamp drivers (registered, Moore)
//   ped_walk          - high while in S_FG
//   ST                - current state code
//
// state | meaning
// S_HG  | highway green, farm red (rest state)
// S_HY  | highway yellow
// S_AR1 | all red before farm green
// S_FG  | farm green, pedestrian walk
// S_FY  | farm yellow
// S_AR2 | all red before highway green
module tl_phase_sequencer
    import tl_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int HG_MIN = 8,
    parameter int FG_MAX = 6,
    parameter int YEL    = 2,
    parameter int ALLRED = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       car,
    input  logic       ped_req,
    input  logic       emg,
    output logic       HG,
    output logic       HY,
    output logic       HR,
    output logic       FG,
    output logic       FY,
    output logic       FR,
    output logic       ped_walk,
    output logic [2:0] ST
);

    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HG_MIN - 1);
    localparam logic [CNT_W-1:0] FG_LAST  = CNT_W'(FG_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED - 1);

    state_t           state_q, state_d, state_nxt;
    logic             ped_pend_q, ped_pend_d;
    logic [5:0]       lamps_q, lamps_d;
    logic             walk_q, walk_d;
    logic [CNT_W-1:0] timer;
    logic             timer_clr;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_HG:  if (timer >= HG_LAST && (car || ped_pend_q) && !emg) state_nxt = S_HY;
            S_HY:  if (timer == YEL_LAST) state_nxt = S_AR1;
            S_AR1: if (timer == AR_LAST)  state_nxt = emg ? S_AR2 : S_FG;
            // Leave farm green on preempt, when demand is gone after the
            // 2-cycle minimum, or at the cap.
            S_FG:  if (emg || (!car && !ped_pend_q && timer != '0) || timer == FG_LAST)
                       state_nxt = S_FY;
            S_FY:  if (timer == YEL_LAST) state_nxt = S_AR2;
            S_AR2: if (timer == AR_LAST)  state_nxt = S_HG;
            default: state_nxt = S_HG;
        endcase
    end

    always_comb begin
        state_d    = enable ? state_nxt : state_q;
        ped_pend_d = ped_pend_q;
        lamps_d    = lamps_q;
        walk_d     = walk_q;
        if (enable) begin
            // Entering farm green serves the request; that wins over a new press.
            if (state_d == S_FG && state_q != S_FG) begin
                ped_pend_d = 1'b0;
            end else if (ped_req) begin
                ped_pend_d = 1'b1;
            end
            lamps_d = lamps_of(state_d);
            walk_d  = (state_d == S_FG);
        end
    end

    assign timer_clr = enable && (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HG;
            ped_pend_q <= 1'b0;
            lamps_q    <= LAMP_HG;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            lamps_q    <= lamps_d;
            walk_q     <= walk_d;
        end
    end

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .clr   (timer_clr),
        .cnt   (timer)
    );

    assign {HG, HY, HR, FG, FY, FR} = lamps_q;
    assign ped_walk = walk_q;
    assign ST       = state_q;

endmodule
